// File: rtl/irq_arbiter.sv
// irq_arbiter: funnels up to NUM_SRC level interrupt requests onto a single
// CPU interrupt line, remembers the winning source and routes the CPU
// acknowledge back to that source only. A 3-register window on the shared
// 8-bit bus exposes PENDING (Base+0), MASK (Base+1) and VECTOR (Base+2).
// Build option: define IRQ_ROUND_ROBIN_EN for rotating priority; the default
// build is fixed priority (lowest index wins).
module irq_arbiter #(
  parameter int         NUM_SRC     = 4,
  parameter logic [7:0] IrqBaseAddr = 8'hE0,
  parameter logic [7:0] InitialMask = 8'hFF
) (
  input  logic               CLK,
  input  logic               RESET_N,
  inout  wire  [7:0]         BUS_DATA,
  input  logic [7:0]         BUS_ADDR,
  input  logic               BUS_WE,
  input  logic [NUM_SRC-1:0] SRC_IRQ_RAISE,
  output logic [NUM_SRC-1:0] SRC_IRQ_ACK,
  output logic               CPU_IRQ_RAISE,
  input  logic               CPU_IRQ_ACK
);

  typedef enum logic [1:0] {IDLE, GRANT, ACKD} state_t;

  localparam logic [7:0] AddrPend = IrqBaseAddr;
  localparam logic [7:0] AddrMask = IrqBaseAddr + 8'd1;
  localparam logic [7:0] AddrVec  = IrqBaseAddr + 8'd2;
  // Bits of an 8-bit register that correspond to real sources.
  localparam logic [7:0] MaskBits = 8'((16'd1 << NUM_SRC) - 16'd1);

  // Read-select encoding of the registered bus select.
  localparam logic [1:0] SelNone = 2'd0;
  localparam logic [1:0] SelPend = 2'd1;
  localparam logic [1:0] SelMask = 2'd2;
  localparam logic [1:0] SelVec  = 2'd3;

  state_t             state_q;
  logic [7:0]         mask_q;      // bits above NUM_SRC are held at 0
  logic [NUM_SRC-1:0] src_ack_q;
  logic [2:0]         vector_q;
  logic               vec_valid_q;
  logic               cpu_irq_q;
  logic [1:0]         rd_sel_q, rd_sel_d;

  logic [7:0]         pend8;
  logic [7:0]         rd_data;
  logic [3:0]         start;
  logic [3:0]         cand;
  logic [2:0]         win_idx;
  logic               found;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [2:0]         last_q;
  // Search begins just after the previous winner, wrapping at NUM_SRC.
  assign start = (last_q == 3'(NUM_SRC-1)) ? 4'd0 : {1'b0, last_q} + 4'd1;
`else
  assign start = 4'd0;
`endif

  // Masked requests; the registered mask is used, so a same-cycle mask write
  // only affects the following evaluation.
  assign pend8 = 8'(SRC_IRQ_RAISE) & mask_q;

  // Priority search from 'start', wrapping; first pending source wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = start + 4'(k);
      if (cand >= 4'(NUM_SRC)) cand = cand - 4'(NUM_SRC);
      if (!found && pend8[cand[2:0]]) begin
        found   = 1'b1;
        win_idx = cand[2:0];
      end
    end
  end

  // Arbitration FSM with registered CPU request and one-cycle source ack.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      cpu_irq_q   <= 1'b0;
      src_ack_q   <= '0;
      vector_q    <= '0;
      vec_valid_q <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
      last_q      <= '0;
`endif
    end else begin
      src_ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q     <= GRANT;
            cpu_irq_q   <= 1'b1;
            vector_q    <= win_idx;
            vec_valid_q <= 1'b1;
`ifdef IRQ_ROUND_ROBIN_EN
            last_q      <= win_idx;
`endif
          end
        end
        // Grant is never revoked; the ack goes to the latched vector even if
        // the source has dropped or been masked meanwhile.
        GRANT: begin
          if (CPU_IRQ_ACK) begin
            state_q   <= ACKD;
            cpu_irq_q <= 1'b0;
            src_ack_q <= NUM_SRC'(1) << vector_q;
          end
        end
        // Dead cycle lets the acked source drop its level before re-evaluation.
        ACKD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Mask register; only Base+1 is writable.
  always_ff @(posedge CLK) begin
    if (!RESET_N) mask_q <= InitialMask & MaskBits;
    else if (BUS_WE && BUS_ADDR == AddrMask) mask_q <= BUS_DATA & MaskBits;
  end

  // Decode a read of the register window; writes never turn on the driver.
  always_comb begin
    rd_sel_d = SelNone;
    if (!BUS_WE) begin
      if      (BUS_ADDR == AddrPend) rd_sel_d = SelPend;
      else if (BUS_ADDR == AddrMask) rd_sel_d = SelMask;
      else if (BUS_ADDR == AddrVec)  rd_sel_d = SelVec;
    end
  end

  // Registered read select: data goes on the bus the cycle after the address.
  always_ff @(posedge CLK) begin
    if (!RESET_N) rd_sel_q <= SelNone;
    else          rd_sel_q <= rd_sel_d;
  end

  // Read data reflects register state at drive time.
  always_comb begin
    rd_data = 8'h00;
    case (rd_sel_q)
      SelPend: rd_data = pend8;
      SelMask: rd_data = mask_q;
      SelVec:  rd_data = {vec_valid_q, 4'b0000, vector_q};
      default: rd_data = 8'h00;
    endcase
  end

  assign BUS_DATA      = (rd_sel_q != SelNone) ? rd_data : 8'hzz;
  assign SRC_IRQ_ACK   = src_ack_q;
  assign CPU_IRQ_RAISE = cpu_irq_q;

endmodule
